serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
Parallel-in, serial-out frame transmitter with a valid/ready load interface. It is the launch end of the single-wire serial link, whose receive end samples the line bit-by-bit into capture flops. It frames each word as start bit, data LSB-first, optional parity, and stop bit, holding each bit for a programmable number of clocks. It sits between a parallel producer and the serial pin.

Parameters:
DATA_W, 8, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (>=1)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
tx_data  input  DATA_W  word to send; sampled only on accept
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  transmitter can accept a word this cycle
tx_out  output  1  serial line; idle level 1
tx_busy  output  1  frame in progress (any state other than IDLE)
tx_done  output  1  one-cycle pulse after the stop bit completes

Behaviour:
- Interface fixed: one clock, clk; reset rst is asynchronous and active-high.
- Reset (async assert, any time): state=IDLE, tx_out=1, tx_ready=1, tx_busy=0, tx_done=0, counters=0. Reset mid-frame aborts the frame immediately and the line returns high. No partial frame resumes after release.
- All outputs are registered. tx_ready is high only in IDLE, and tx_busy is its inverse.
- Accept: on the rising edge where tx_valid&&tx_ready, tx_data is latched into a shift register and the state goes to START. tx_out=0 from the next cycle.
- A tx_valid seen while not ready is ignored and does not queue. Changing tx_data after accept has no effect on the frame in flight.
- FSM states:
  - IDLE: tx_out=1.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: bit i (i=0..DATA_W-1, LSB first) for CLKS_PER_BIT cycles each.
  - PARITY: only with the optional feature enabled.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Counters:
  - Cycle counter 0..CLKS_PER_BIT-1 wraps to 0 at each bit boundary.
  - Bit index 0..DATA_W-1 advances on cycle-counter wrap.
  - Widths are $clog2 of the range, with a minimum of 1 bit.
  - CLKS_PER_BIT=1 means one bit per clock with no stall cycles.
- tx_done is high for exactly one cycle: the first IDLE cycle after STOP. tx_ready is also high in that cycle.
- Back-to-back: a word offered in the tx_done cycle is accepted. The minimum idle gap between frames is therefore 1 clock of line-high beyond the stop bit.
- Frame length from first start-bit cycle to last stop-bit cycle: (DATA_W+2)*CLKS_PER_BIT clocks, plus CLKS_PER_BIT with parity.
- Reset asserted during the accept edge: reset wins and the word is dropped.

Optional Feature:
SERIAL_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles, and the frame grows by one bit.
- Undefined: no PARITY state or parity logic exists, and DATA goes directly to STOP.

Test Plan:
- Single word, DATA_W=8, CLKS_PER_BIT=4, tx_data=0xA5 accepted at cycle 0 -> tx_out from cycle 1 is 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles (40 cycles) -> tx_done=1 at cycle 41 only; tx_ready=0 and tx_busy=1 during cycles 1-40.
- Back-to-back: 0x00 then 0xFF with tx_valid held high -> second accept occurs in the tx_done cycle; exactly one high gap cycle between frames; second frame data bits all 1.
- Valid while busy: tx_valid pulses with 0x3C mid-frame of 0x81 -> 0x3C never appears on tx_out; 0x81 frame unaltered; tx_data toggled after accept also has no effect.
- Reset mid-frame: rst asserted during DATA bit 3 -> tx_out=1, tx_ready=1, tx_busy=0 in the same cycle (asynchronous); no tx_done; after release, a new 0x55 sends a clean full frame.
- CLKS_PER_BIT=1, DATA_W=8, 0xF0 -> 10 consecutive cycles 0,0,0,0,0,1,1,1,1,1, then tx_done.
- SERIAL_TX_PARITY_EN defined, 0x07 -> parity bit 1 after MSB, frame 11 bits; 0x03 -> parity bit 0.

Source files
------------

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, DATA_W data bits
// LSB first, optional even-parity bit, stop bit, each held CLKS_PER_BIT clocks.
// Define SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module serial_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0]    r_bit, w_bit_nxt;
  logic [DATA_W-1:0]   r_shift, w_shift_nxt;
  logic                r_tx_out, w_tx_out_nxt;
  logic                r_tx_ready, w_tx_ready_nxt;
  logic                r_tx_busy, w_tx_busy_nxt;
  logic                r_tx_done, w_tx_done_nxt;
  logic                w_wrap;
`ifdef SERIAL_TX_PARITY_EN
  logic                r_parity, w_parity_nxt;
`endif

  assign w_wrap = (r_cnt == CNT_LAST);

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_tx_out   <= 1'b1;
      r_tx_ready <= 1'b1;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_tx_out   <= w_tx_out_nxt;
      r_tx_ready <= w_tx_ready_nxt;
      r_tx_busy  <= w_tx_busy_nxt;
      r_tx_done  <= w_tx_done_nxt;
`ifdef SERIAL_TX_PARITY_EN
      r_parity   <= w_parity_nxt;
`endif
    end
  end

  // Next-state logic; outputs are computed from the next state so they register in step with it
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_tx_done_nxt  = 1'b0;
    w_tx_out_nxt   = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
    w_parity_nxt   = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_shift_nxt = tx_data;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = S_START;
`ifdef SERIAL_TX_PARITY_EN
          w_parity_nxt = ^tx_data;
`endif
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          w_cnt_nxt = '0;
          if (r_bit == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
            w_shift_nxt = r_shift >> 1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (w_wrap) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_wrap) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
          w_tx_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = '0;
      end
    endcase

    case (w_state_nxt)
      S_START:    w_tx_out_nxt = 1'b0;
      S_DATA:     w_tx_out_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY:   w_tx_out_nxt = w_parity_nxt;
`endif
      default:    w_tx_out_nxt = 1'b1;
    endcase

    w_tx_ready_nxt = (w_state_nxt == S_IDLE);
    w_tx_busy_nxt  = (w_state_nxt != S_IDLE);
  end

  assign tx_out   = r_tx_out;
  assign tx_ready = r_tx_ready;
  assign tx_busy  = r_tx_busy;
  assign tx_done  = r_tx_done;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (CLKS_PER_BIT=4 and 1), per-cycle
// expected line state queued at each accept and checked at every falling edge.
module tb_serial_tx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned FRAME_BITS = DW + 2 + PAR;
  localparam int BOUND = 500;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] d0_data, d1_data;
  logic          d0_valid, d1_valid;
  logic          d0_ready, d0_out, d0_busy, d0_done;
  logic          d1_ready, d1_out, d1_busy, d1_done;

  int vectors     = 0;
  int miscompares = 0;

  // Expected per-cycle {out, busy, done}; empty queue means idle
  logic [2:0] q0[$];
  logic [2:0] q1[$];

  always #5 clk = ~clk;

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) u_dut0 (
    .clk(clk), .rst(rst), .tx_data(d0_data), .tx_valid(d0_valid),
    .tx_ready(d0_ready), .tx_out(d0_out), .tx_busy(d0_busy), .tx_done(d0_done)
  );

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .tx_data(d1_data), .tx_valid(d1_valid),
    .tx_ready(d1_ready), .tx_out(d1_out), .tx_busy(d1_busy), .tx_done(d1_done)
  );

  // Scoreboard checkers for each instance
  always @(negedge clk) begin : mon0
    logic [2:0] e;
    if (!rst) begin
      e = (q0.size() > 0) ? q0.pop_front() : 3'b100;
      vectors++;
      if ({d0_out, d0_busy, d0_ready, d0_done} !== {e[2], e[1], ~e[1], e[0]}) begin
        miscompares++;
        $display("FAIL mon0 @%0t out/busy/ready/done got %b%b%b%b want %b%b%b%b", $time,
                 d0_out, d0_busy, d0_ready, d0_done, e[2], e[1], ~e[1], e[0]);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [2:0] e;
    if (!rst) begin
      e = (q1.size() > 0) ? q1.pop_front() : 3'b100;
      vectors++;
      if ({d1_out, d1_busy, d1_ready, d1_done} !== {e[2], e[1], ~e[1], e[0]}) begin
        miscompares++;
        $display("FAIL mon1 @%0t out/busy/ready/done got %b%b%b%b want %b%b%b%b", $time,
                 d1_out, d1_busy, d1_ready, d1_done, e[2], e[1], ~e[1], e[0]);
      end
    end
  end

  function automatic void push_frame(input int which, input logic [DW-1:0] d, input int cpb);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < int'(DW); i++) bits.push_back(d[i]);
`ifdef SERIAL_TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c < cpb; c++) begin
        if (which == 0) q0.push_back({bits[k], 2'b10});
        else            q1.push_back({bits[k], 2'b10});
      end
    end
    if (which == 0) q0.push_back(3'b101);
    else            q1.push_back(3'b101);
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  // Called at posedge+1; waits until the model says ready, accepts on the next edge
  task automatic send(input int which, input logic [DW-1:0] d, input bit hold);
    int n = 0;
    if (which == 0) begin d0_data = d; d0_valid = 1'b1; end
    else            begin d1_data = d; d1_valid = 1'b1; end
    while (qsize(which) > 1 && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= BOUND) begin
      vectors++; miscompares++;
      $display("FAIL send_wait dut%0d got timeout want ready", which);
    end
    @(posedge clk); #1;
    push_frame(which, d, (which == 0) ? int'(CPB) : 1);
    if (!hold) begin
      if (which == 0) d0_valid = 1'b0;
      else            d1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int which);
    int n = 0;
    while (qsize(which) > 0 && n < BOUND) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= BOUND) begin
      miscompares++;
      $display("FAIL wait_idle dut%0d got %0d queued want 0", which, qsize(which));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    d0_valid = 1'b0; d1_valid = 1'b0;
    d0_data = '0;    d1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({d0_out, d0_ready, d0_busy, d0_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset0 out/ready/busy/done got %b%b%b%b want 1100", d0_out, d0_ready, d0_busy, d0_done);
    end
    vectors++;
    if ({d1_out, d1_ready, d1_busy, d1_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset1 out/ready/busy/done got %b%b%b%b want 1100", d1_out, d1_ready, d1_busy, d1_done);
    end
    rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Measures accept-to-done latency on top of the scoreboard
  task automatic test_single();
    int n = 0;
    send(0, 8'hA5, 1'b0);
    while (!d0_done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != int'(FRAME_BITS * CPB + 1)) begin
      miscompares++;
      $display("FAIL single_done_latency got %0d want %0d", n, FRAME_BITS * CPB + 1);
    end
    @(posedge clk); #1;
    wait_idle(0);
  endtask

  task automatic test_back_to_back();
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b0);
    wait_idle(0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_valid_while_busy();
    send(0, 8'h81, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    d0_data = 8'h3C; d0_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    d0_valid = 1'b0;
    repeat (10) begin
      d0_data = 8'($urandom);
      @(posedge clk); #1;
    end
    wait_idle(0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset_midframe();
    send(0, 8'hA5, 1'b0);
    repeat (17) @(posedge clk);
    #2;
    rst = 1'b1;
    q0.delete();
    #1;
    vectors++;
    if ({d0_out, d0_ready, d0_busy, d0_done} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_midframe out/ready/busy/done got %b%b%b%b want 1100", d0_out, d0_ready, d0_busy, d0_done);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    send(0, 8'h55, 1'b0);
    wait_idle(0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic test_cpb1();
    int n = 0;
    send(1, 8'hF0, 1'b0);
    while (!d1_done && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != int'(FRAME_BITS + 1)) begin
      miscompares++;
      $display("FAIL cpb1_done_latency got %0d want %0d", n, FRAME_BITS + 1);
    end
    @(posedge clk); #1;
    wait_idle(1);
    send(1, 8'h5A, 1'b1);
    send(1, 8'hC3, 1'b0);
    wait_idle(1);
    repeat (2) begin @(posedge clk); #1; end
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    send(0, 8'h07, 1'b0);
    repeat (36) @(posedge clk);
    #1;
    vectors++;
    if (d0_out !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_07 got %b want 1", d0_out);
    end
    wait_idle(0);
    send(0, 8'h03, 1'b0);
    repeat (36) @(posedge clk);
    #1;
    vectors++;
    if (d0_out !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_03 got %b want 0", d0_out);
    end
    wait_idle(0);
    repeat (2) begin @(posedge clk); #1; end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_valid_while_busy();
    test_reset_midframe();
    test_cpb1();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
